// File: rtl/uart_tx_frame_checker_if.sv
// Signal bundle between a UART transmitter environment (master: serial line and stimulus)
// and the passive frame checker (slave: per-frame report and counters).
interface uart_tx_frame_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  tx_out;
  logic                  busy;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  data_valid;
  logic                  frame_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  parity_err;
  logic                  framing_err;
  logic                  mismatch_err;
  logic                  busy_err;
  logic                  unexp_frame;
  logic                  exp_overrun;
  logic [CNT_WIDTH-1:0]  frame_cnt;
  logic [CNT_WIDTH-1:0]  err_cnt;

  modport master (
    output tx_out, busy, p_data, par_en, par_typ, data_valid,
    input  frame_valid, rx_data, parity_err, framing_err, mismatch_err, busy_err,
    input  unexp_frame, exp_overrun, frame_cnt, err_cnt
  );

  modport slave (
    input  tx_out, busy, p_data, par_en, par_typ, data_valid,
    output frame_valid, rx_data, parity_err, framing_err, mismatch_err, busy_err,
    output unexp_frame, exp_overrun, frame_cnt, err_cnt
  );
endinterface

// File: rtl/uart_tx_frame_checker.sv
// Passive UART TX frame checker; report one cycle after the last stop period, never backpressures.
// UART_CHK_DISPLAY_EN adds simulation-only $display of each frame and overrun warnings.
module uart_tx_frame_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_frame_checker_if.slave bus
);
  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] SAMPLE_IDX = BCW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BCW-1:0] LAST_IDX   = BCW'(CLKS_PER_BIT - 1);
  localparam logic [IDW-1:0] LAST_BIT   = IDW'(DATA_WIDTH - 1);
  localparam logic           LAST_STOP  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

  state_t                state_q, state_d, cur_state;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d, cur_cnt;
  logic [IDW-1:0]        bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, berr_q, berr_d;
  logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
  logic                  exp_par_en_q, exp_par_en_d, exp_par_typ_q, exp_par_typ_d;
  logic                  exp_pending_q, exp_pending_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  parity_err_q, parity_err_d, framing_err_q, framing_err_d;
  logic                  mismatch_err_q, mismatch_err_d, busy_err_q, busy_err_d;
  logic                  unexp_frame_q, unexp_frame_d, exp_overrun_q, exp_overrun_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic                  active, sample, period_end, report, capture, mis, any_err;

  always_comb begin
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    berr_d     = berr_q;
    report     = 1'b0;
    cur_state  = state_q;
    cur_cnt    = bit_cnt_q;
    // The cycle the line first drops is already cycle 0 of the start bit.
    if (state_q == S_IDLE && !bus.tx_out) begin
      cur_state = S_START;
      cur_cnt   = '0;
      par_en_d  = exp_par_en_q;
      par_typ_d = exp_par_typ_q;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      berr_d    = 1'b0;
    end
    state_d    = cur_state;
    active     = cur_state inside {S_START, S_DATA, S_PARITY, S_STOP};
    sample     = active && (cur_cnt == SAMPLE_IDX);
    period_end = active && (cur_cnt == LAST_IDX);
    bit_cnt_d  = (!active || period_end) ? '0 : cur_cnt + 1'b1;
    if (sample && !bus.busy) berr_d = 1'b1;

    case (cur_state)
      S_IDLE: ;
      S_START: begin
        if (sample && bus.tx_out) begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end else if (period_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (sample) shift_d = {bus.tx_out, shift_q[DATA_WIDTH-1:1]};
        if (period_end) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample && (bus.tx_out != (^shift_q ^ par_typ_q))) perr_d = 1'b1;
        if (period_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_STOP: begin
        if (sample && !bus.tx_out) ferr_d = 1'b1;
        if (period_end) begin
          if (stop_idx_q == LAST_STOP) begin
            report  = 1'b1;
            state_d = bus.tx_out ? S_IDLE : S_WAIT_HIGH;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      S_WAIT_HIGH: if (bus.tx_out) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    capture        = bus.data_valid && !bus.busy;
    mis            = exp_pending_q && (shift_q != exp_data_q);
    any_err        = perr_d | ferr_d | mis | berr_d | !exp_pending_q;
    exp_data_d     = capture ? bus.p_data : exp_data_q;
    exp_par_en_d   = capture ? bus.par_en : exp_par_en_q;
    exp_par_typ_d  = capture ? bus.par_typ : exp_par_typ_q;
    // A capture coinciding with a report refills the slot the report just consumed.
    exp_pending_d  = capture ? 1'b1 : (report ? 1'b0 : exp_pending_q);
    exp_overrun_d  = capture && exp_pending_q && !report;
    frame_valid_d  = report;
    rx_data_d      = report ? shift_q : rx_data_q;
    parity_err_d   = report && perr_d;
    framing_err_d  = report && ferr_d;
    mismatch_err_d = report && mis;
    busy_err_d     = report && berr_d;
    unexp_frame_d  = report && !exp_pending_q;
    frame_cnt_d    = (report && frame_cnt_q != '1) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    err_cnt_d      = (report && any_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      bit_idx_q      <= '0;
      stop_idx_q     <= 1'b0;
      shift_q        <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      berr_q         <= 1'b0;
      exp_data_q     <= '0;
      exp_par_en_q   <= 1'b0;
      exp_par_typ_q  <= 1'b0;
      exp_pending_q  <= 1'b0;
      frame_valid_q  <= 1'b0;
      rx_data_q      <= '0;
      parity_err_q   <= 1'b0;
      framing_err_q  <= 1'b0;
      mismatch_err_q <= 1'b0;
      busy_err_q     <= 1'b0;
      unexp_frame_q  <= 1'b0;
      exp_overrun_q  <= 1'b0;
      frame_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      bit_idx_q      <= bit_idx_d;
      stop_idx_q     <= stop_idx_d;
      shift_q        <= shift_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      berr_q         <= berr_d;
      exp_data_q     <= exp_data_d;
      exp_par_en_q   <= exp_par_en_d;
      exp_par_typ_q  <= exp_par_typ_d;
      exp_pending_q  <= exp_pending_d;
      frame_valid_q  <= frame_valid_d;
      rx_data_q      <= rx_data_d;
      parity_err_q   <= parity_err_d;
      framing_err_q  <= framing_err_d;
      mismatch_err_q <= mismatch_err_d;
      busy_err_q     <= busy_err_d;
      unexp_frame_q  <= unexp_frame_d;
      exp_overrun_q  <= exp_overrun_d;
      frame_cnt_q    <= frame_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign bus.frame_valid  = frame_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.framing_err  = framing_err_q;
  assign bus.mismatch_err = mismatch_err_q;
  assign bus.busy_err     = busy_err_q;
  assign bus.unexp_frame  = unexp_frame_q;
  assign bus.exp_overrun  = exp_overrun_q;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.err_cnt      = err_cnt_q;

`ifdef UART_CHK_DISPLAY_EN
  always @(posedge clk) begin
    if (reset && frame_valid_q)
      $display("%0t uart_chk frame rx=%h exp=%h par=%b frm=%b cmp=%b busy=%b unexp=%b", $time,
               rx_data_q, exp_data_q, parity_err_q, framing_err_q, mismatch_err_q, busy_err_q,
               unexp_frame_q);
    if (reset && exp_overrun_q)
      $display("%0t uart_chk warning: expected word overwritten before its frame", $time);
  end
`endif
endmodule

// File: tb/tb_uart_tx_frame_checker.sv
// Bench for uart_tx_frame_checker: dut0 uses defaults, dut1 uses CLKS_PER_BIT=4, STOP_BITS=2.
module tb_uart_tx_frame_checker;
  localparam int W  = 8;
  localparam int CW = 16;

  typedef struct packed {
    logic [W-1:0] d;
    logic pe, fe, me, be, ue;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, line0, line1, busy, par_en, par_typ, data_valid;
  logic [W-1:0] p_data;

  uart_tx_frame_checker_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) b0 ();
  uart_tx_frame_checker_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) b1 ();

  assign b0.tx_out = line0;      assign b1.tx_out = line1;
  assign b0.busy = busy;         assign b1.busy = busy;
  assign b0.p_data = p_data;     assign b1.p_data = p_data;
  assign b0.par_en = par_en;     assign b1.par_en = par_en;
  assign b0.par_typ = par_typ;   assign b1.par_typ = par_typ;
  assign b0.data_valid = data_valid;
  assign b1.data_valid = data_valid;

  uart_tx_frame_checker #(.DATA_WIDTH(W), .STOP_BITS(1), .CLKS_PER_BIT(1), .CNT_WIDTH(CW))
    dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  uart_tx_frame_checker #(.DATA_WIDTH(W), .STOP_BITS(2), .CLKS_PER_BIT(4), .CNT_WIDTH(CW))
    dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  int total = 0;
  int bad = 0;
  rec_t q0[$], q1[$], eq0[$], eq1[$];
  int ovr0 = 0, ovr1 = 0;

  // Reference model: expected slot and counters per checker instance.
  logic         m_pend [2];
  logic [W-1:0] m_exp  [2];
  logic         m_pen  [2];
  logic         m_ptyp [2];
  logic [CW-1:0] m_frames [2];
  logic [CW-1:0] m_errs   [2];
  int           m_ovr  [2];

  always @(negedge clk) begin
    if (b0.frame_valid === 1'b1)
      q0.push_back({b0.rx_data, b0.parity_err, b0.framing_err, b0.mismatch_err, b0.busy_err, b0.unexp_frame});
    if (b1.frame_valid === 1'b1)
      q1.push_back({b1.rx_data, b1.parity_err, b1.framing_err, b1.mismatch_err, b1.busy_err, b1.unexp_frame});
    if (b0.exp_overrun === 1'b1) ovr0++;
    if (b1.exp_overrun === 1'b1) ovr1++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_pend[w] = 1'b0; m_exp[w] = '0; m_pen[w] = 1'b0; m_ptyp[w] = 1'b0;
      m_frames[w] = '0; m_errs[w] = '0;
    end
  endtask

  task automatic load(input logic [W-1:0] d, input logic pe, input logic pt);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1; busy = 1'b0;
    @(posedge clk); #1;
    data_valid = 1'b0; busy = 1'b1;
    for (int w = 0; w < 2; w++) begin
      if (m_pend[w]) m_ovr[w]++;
      m_pend[w] = 1'b1; m_exp[w] = d; m_pen[w] = pe; m_ptyp[w] = pt;
    end
  endtask

  task automatic send(input int which, input logic [W-1:0] d, input bit corrupt,
                      input logic [1:0] mask, input bit bdrop);
    logic bits[$];
    rec_t e;
    int cpb, nst;
    logic [1:0] m;
    cpb = (which == 0) ? 1 : 4;
    nst = (which == 0) ? 1 : 2;
    m = mask & ((which == 0) ? 2'b01 : 2'b11);
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (m_pen[which]) bits.push_back((^d) ^ m_ptyp[which] ^ corrupt);
    for (int s = 0; s < nst; s++) bits.push_back(!m[s]);
    for (int b = 0; b < bits.size(); b++) begin
      busy = !(bdrop && b == 3);
      for (int c = 0; c < cpb; c++) begin
        if (which == 0) line0 = bits[b]; else line1 = bits[b];
        @(posedge clk); #1;
      end
    end
    busy = 1'b1;
    e.d  = d;
    e.pe = m_pen[which] && corrupt;
    e.fe = |m;
    e.me = m_pend[which] && (d != m_exp[which]);
    e.be = bdrop;
    e.ue = !m_pend[which];
    if (which == 0) eq0.push_back(e); else eq1.push_back(e);
    m_pend[which] = 1'b0;
    if (m_frames[which] != '1) m_frames[which] = m_frames[which] + 1'b1;
    if ((e.pe | e.fe | e.me | e.be | e.ue) && m_errs[which] != '1) m_errs[which] = m_errs[which] + 1'b1;
  endtask

  task automatic test_reset();
    logic [W+CW*2+6:0] v;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1; model_reset();
    @(negedge clk);
    v = {b0.frame_valid, b0.rx_data, b0.parity_err, b0.framing_err, b0.mismatch_err, b0.busy_err,
         b0.unexp_frame, b0.exp_overrun, b0.frame_cnt, b0.err_cnt};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_dut0: got %h need 0", v); end
    v = {b1.frame_valid, b1.rx_data, b1.parity_err, b1.framing_err, b1.mismatch_err, b1.busy_err,
         b1.unexp_frame, b1.exp_overrun, b1.frame_cnt, b1.err_cnt};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_dut1: got %h need 0", v); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frames_basic();
    rec_t o, e;
    load(8'hA5, 1'b1, 1'b0);
    send(0, 8'hA5, 1'b0, 2'b00, 1'b0);
    load(8'hA5, 1'b1, 1'b0);
    send(0, 8'hA5, 1'b1, 2'b00, 1'b0);
    for (int k = 0; k < 20 && q0.size() < eq0.size(); k++) @(negedge clk);
    while (eq0.size() > 0) begin
      e = eq0.pop_front(); total++;
      if (q0.size() == 0) begin bad++; $display("FAIL basic_frame: got none need %h", e); end
      else begin
        o = q0.pop_front();
        if (o !== e) begin bad++; $display("FAIL basic_frame: got %h need %h", o, e); end
      end
    end
    @(negedge clk); total++;
    if ({b0.frame_cnt, b0.err_cnt} !== {m_frames[0], m_errs[0]})
      begin bad++; $display("FAIL basic_cnt: got %0d/%0d need %0d/%0d", b0.frame_cnt, b0.err_cnt, m_frames[0], m_errs[0]); end
  endtask

  task automatic test_framing();
    rec_t o, e;
    load(8'h3C, 1'b0, 1'b0);
    send(0, 8'h3C, 1'b0, 2'b01, 1'b0);
    line0 = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    total++;
    if (q0.size() !== 1) begin bad++; $display("FAIL framing_wait_high: got %0d frames need 1", q0.size()); end
    while (eq0.size() > 0) begin
      e = eq0.pop_front(); total++;
      if (q0.size() == 0) begin bad++; $display("FAIL framing_frame: got none need %h", e); end
      else begin
        o = q0.pop_front();
        if (o !== e) begin bad++; $display("FAIL framing_frame: got %h need %h", o, e); end
      end
    end
    q0.delete();
    line0 = 1'b1; @(posedge clk); #1;
    load(8'h81, 1'b1, 1'b1);
    send(0, 8'h81, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 20 && q0.size() < eq0.size(); k++) @(negedge clk);
    e = eq0.pop_front(); total++;
    if (q0.size() == 0) begin bad++; $display("FAIL framing_recover: got none need %h", e); end
    else begin
      o = q0.pop_front();
      if (o !== e) begin bad++; $display("FAIL framing_recover: got %h need %h", o, e); end
    end
  endtask

  task automatic test_mismatch_overrun();
    rec_t o, e;
    load(8'h55, 1'b0, 1'b0);
    load(8'h55, 1'b0, 1'b0);
    send(0, 8'hAA, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 20 && q0.size() < eq0.size(); k++) @(negedge clk);
    e = eq0.pop_front(); total++;
    if (q0.size() == 0) begin bad++; $display("FAIL mismatch_frame: got none need %h", e); end
    else begin
      o = q0.pop_front();
      if (o !== e) begin bad++; $display("FAIL mismatch_frame: got %h need %h", o, e); end
    end
    total++;
    if (ovr0 !== m_ovr[0]) begin bad++; $display("FAIL overrun_count: got %0d need %0d", ovr0, m_ovr[0]); end
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    load(8'h12, 1'b1, 1'b1);
    send(0, 8'h12, 1'b0, 2'b00, 1'b0);
    send(0, 8'h34, 1'b0, 2'b00, 1'b0);
    send(0, 8'hC7, 1'b1, 2'b00, 1'b1);
    for (int k = 0; k < 20 && q0.size() < eq0.size(); k++) @(negedge clk);
    while (eq0.size() > 0) begin
      e = eq0.pop_front(); total++;
      if (q0.size() == 0) begin bad++; $display("FAIL b2b_frame: got none need %h", e); end
      else begin
        o = q0.pop_front();
        if (o !== e) begin bad++; $display("FAIL b2b_frame: got %h need %h", o, e); end
      end
    end
  endtask

  task automatic test_random(input int which, input int n);
    rec_t o, e;
    logic [W-1:0] d;
    logic [1:0] mask;
    for (int i = 0; i < n; i++) begin
      d = W'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        load($urandom_range(0, 1) == 0 ? d : W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) load(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      mask = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      send(which, d, $urandom_range(0, 3) == 0, mask, $urandom_range(0, 5) == 0);
      if (line0 === 1'b0 || line1 === 1'b0) begin line0 = 1'b1; line1 = 1'b1; @(posedge clk); #1; end
      for (int k = 0; k < 20 && (which == 0 ? q0.size() : q1.size()) == 0; k++) @(negedge clk);
      e = (which == 0) ? eq0.pop_front() : eq1.pop_front();
      total++;
      if ((which == 0 ? q0.size() : q1.size()) == 0) begin bad++; $display("FAIL random_frame%0d: got none need %h", which, e); end
      else begin
        o = (which == 0) ? q0.pop_front() : q1.pop_front();
        if (o !== e) begin bad++; $display("FAIL random_frame%0d: got %h need %h", which, o, e); end
      end
      @(negedge clk); total++;
      if (which == 0 && {b0.frame_cnt, b0.err_cnt} !== {m_frames[0], m_errs[0]})
        begin bad++; $display("FAIL random_cnt0: got %0d/%0d need %0d/%0d", b0.frame_cnt, b0.err_cnt, m_frames[0], m_errs[0]); end
      if (which == 1 && {b1.frame_cnt, b1.err_cnt} !== {m_frames[1], m_errs[1]})
        begin bad++; $display("FAIL random_cnt1: got %0d/%0d need %0d/%0d", b1.frame_cnt, b1.err_cnt, m_frames[1], m_errs[1]); end
    end
    repeat (2) @(negedge clk);
    total++;
    if (ovr0 !== m_ovr[0] || ovr1 !== m_ovr[1])
      begin bad++; $display("FAIL random_overrun: got %0d/%0d need %0d/%0d", ovr0, ovr1, m_ovr[0], m_ovr[1]); end
  endtask

  task automatic test_slow_glitch();
    rec_t o, e;
    line1 = 1'b0; @(posedge clk); #1;
    line1 = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    total++;
    if (q1.size() !== 0) begin bad++; $display("FAIL glitch: got %0d frames need 0", q1.size()); end
    load(8'hF0, 1'b1, 1'b0);
    send(1, 8'hF0, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 20 && q1.size() < eq1.size(); k++) @(negedge clk);
    e = eq1.pop_front(); total++;
    if (q1.size() == 0) begin bad++; $display("FAIL slow_frame: got none need %h", e); end
    else begin
      o = q1.pop_front();
      if (o !== e) begin bad++; $display("FAIL slow_frame: got %h need %h", o, e); end
    end
    @(negedge clk); total++;
    if (b1.frame_cnt !== m_frames[1]) begin bad++; $display("FAIL slow_cnt: got %0d need %0d", b1.frame_cnt, m_frames[1]); end
  endtask

  task automatic test_reset_mid_frame();
    rec_t o, e;
    logic [W+CW*2+6:0] v;
    load(8'h77, 1'b0, 1'b0);
    line0 = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin line0 = 1'(i % 2); @(posedge clk); #1; end
    reset = 1'b0; line0 = 1'b1; line1 = 1'b1;
    @(posedge clk); #1;
    model_reset();
    v = {b0.frame_valid, b0.rx_data, b0.parity_err, b0.framing_err, b0.mismatch_err, b0.busy_err,
         b0.unexp_frame, b0.exp_overrun, b0.frame_cnt, b0.err_cnt};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_mid: got %h need 0", v); end
    reset = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    total++;
    if (q0.size() !== 0) begin bad++; $display("FAIL reset_discard: got %0d frames need 0", q0.size()); end
    load(8'h6B, 1'b1, 1'b0);
    send(0, 8'h6B, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 20 && q0.size() < eq0.size(); k++) @(negedge clk);
    e = eq0.pop_front(); total++;
    if (q0.size() == 0) begin bad++; $display("FAIL reset_after: got none need %h", e); end
    else begin
      o = q0.pop_front();
      if (o !== e) begin bad++; $display("FAIL reset_after: got %h need %h", o, e); end
    end
    @(negedge clk); total++;
    if ({b0.frame_cnt, b0.err_cnt} !== {m_frames[0], m_errs[0]})
      begin bad++; $display("FAIL reset_after_cnt: got %0d/%0d need %0d/%0d", b0.frame_cnt, b0.err_cnt, m_frames[0], m_errs[0]); end
  endtask

  initial begin
    reset = 1'b0; line0 = 1'b1; line1 = 1'b1; busy = 1'b1;
    data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
    m_ovr[0] = 0; m_ovr[1] = 0;
    model_reset();
    #1;
    test_reset();
    test_frames_basic();
    test_framing();
    test_mismatch_overrun();
    test_back_to_back();
    test_random(0, 30);
    test_slow_glitch();
    test_random(1, 6);
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
